// File: rtl/bconv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the binary-conv window generator.
// master drives pixels and window back-pressure; slave is the generator.
interface bconv_window_gen_if;
   logic       pix_i;
   logic       pix_valid;
   logic       pix_ready;
   logic [8:0] window_o;
   logic       win_valid;
   logic       win_ready;
   logic       win_last;
   logic       frame_done;

   modport master (
      output pix_i, pix_valid, win_ready,
      input  pix_ready, window_o, win_valid, win_last, frame_done
   );

   modport slave (
      input  pix_i, pix_valid, win_ready,
      output pix_ready, window_o, win_valid, win_last, frame_done
   );
endinterface

// File: rtl/bconv_window_gen.sv
// 3x3 sliding-window generator over a raster-order binary image, feeding an
// XNOR-popcount convolver. Two line buffers plus a two-column shift window.
//
// state     | meaning
// ST_STREAM | normal streaming, pixels accepted when the output slot is free
// ST_DRAIN  | last window of the frame pending, pixel input held off
module bconv_window_gen #(
   parameter int INPUT_H = 28,
   parameter int INPUT_W = 28
) (
   input logic               clk,
   input logic               rst,
   bconv_window_gen_if.slave bus
);
   localparam int            CW       = $clog2(INPUT_W);
   localparam int            RW       = $clog2(INPUT_H);
   localparam logic [CW-1:0] COL_LAST = CW'(INPUT_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(INPUT_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   typedef enum logic {
      ST_STREAM = 1'b0,
      ST_DRAIN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_col;
   logic [RW-1:0]      r_row;
   logic [INPUT_W-1:0] r_lb1;
   logic [INPUT_W-1:0] r_lb2;
   logic [2:0]         r_c1;
   logic [2:0]         r_c2;
   logic [8:0]         r_window;
   logic               r_win_valid;
   logic               r_win_last;
   logic               r_frame_done;

   logic               w_pix_ready;
   logic               w_accept;
   logic               w_handshake;
   logic               w_emit;
   logic               w_last_pix;
   logic [2:0]         w_c0;
   logic [8:0]         w_window;

   assign w_pix_ready = (r_state == ST_STREAM) && (!r_win_valid || bus.win_ready);
   assign w_accept    = bus.pix_valid && w_pix_ready;
   assign w_handshake = r_win_valid && bus.win_ready;

   // Columns are {row-2, row-1, row}; r_c2 is col-2, r_c1 is col-1.
   assign w_c0     = {r_lb2[r_col], r_lb1[r_col], bus.pix_i};
   assign w_window = {r_c2[2], r_c1[2], w_c0[2],
                      r_c2[1], r_c1[1], w_c0[1],
                      r_c2[0], r_c1[0], w_c0[0]};

   assign w_emit     = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
   assign w_last_pix = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);

   // Line buffers need no reset: rows 0 and 1 never produce windows.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb2[r_col] <= r_lb1[r_col];
         r_lb1[r_col] <= bus.pix_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_STREAM;
         r_col        <= '0;
         r_row        <= '0;
         r_c1         <= '0;
         r_c2         <= '0;
         r_window     <= '0;
         r_win_valid  <= 1'b0;
         r_win_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_handshake && r_win_last;

         if (w_accept) begin
            r_c2 <= r_c1;
            r_c1 <= w_c0;
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         // A new window can only be loaded when the slot is free or handing off.
         if (w_emit) begin
            r_window    <= w_window;
            r_win_valid <= 1'b1;
            r_win_last  <= w_last_pix;
         end else if (w_handshake) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
         end

         case (r_state)
            ST_STREAM: if (w_last_pix) r_state <= ST_DRAIN;
            ST_DRAIN:  if (w_handshake && r_win_last) r_state <= ST_STREAM;
            default:   r_state <= ST_STREAM;
         endcase
      end
   end

   assign bus.pix_ready  = w_pix_ready;
   assign bus.window_o   = r_window;
   assign bus.win_valid  = r_win_valid;
   assign bus.win_last   = r_win_last;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_bconv_window_gen.sv
// Directed bench for bconv_window_gen at 28x28: full frames, patterns,
// back-pressure, mid-frame reset and back-to-back frames.
module tb_bconv_window_gen;
   localparam int H    = 28;
   localparam int W    = 28;
   localparam int NPIX = H * W;
   localparam int NWIN = (H - 2) * (W - 2);

   logic clk = 1'b0;
   logic rst;

   bconv_window_gen_if bus ();

   bconv_window_gen #(.INPUT_H(H), .INPUT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic       img [0:H-1][0:W-1];
   logic [8:0] q_win  [$];
   logic       q_last [$];
   int         q_cyc  [$];
   int         q_acc  [$];
   int         cyc       = 0;
   int         acc       = 0;
   int         fd_cnt    = 0;
   int         fd_cyc    = 0;
   int         stall_cnt = 0;

   // Inputs change just after posedge; everything is observed at negedge,
   // so what is seen here is what the next rising edge will act on.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.win_valid && bus.win_ready) begin
            q_win.push_back(bus.window_o);
            q_last.push_back(bus.win_last);
            q_cyc.push_back(cyc);
            q_acc.push_back(acc);
         end
         if (bus.pix_valid && bus.pix_ready) acc++;
         if (bus.pix_valid && !bus.pix_ready) stall_cnt++;
         if (bus.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
      end
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] exp_win(input int r, input int c);
      logic [8:0] w;
      w = '0;
      for (int kr = 0; kr < 3; kr++)
         for (int kc = 0; kc < 3; kc++)
            w[8 - (3 * kr + kc)] = img[r - 2 + kr][c - 2 + kc];
      return w;
   endfunction

   task automatic clear_state();
      q_win.delete();
      q_last.delete();
      q_cyc.delete();
      q_acc.delete();
      acc       = 0;
      fd_cnt    = 0;
      fd_cyc    = 0;
      stall_cnt = 0;
   endtask

   task automatic send_pixels(input int first, input int count);
      for (int p = first; p < first + count; p++) begin
         int t;
         t = 0;
         bus.pix_valid = 1'b1;
         bus.pix_i     = img[(p % NPIX) / W][p % W];
         @(negedge clk);
         while (!bus.pix_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (!bus.pix_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL pix_accept_timeout: pixel %0d pix_ready=%0b after %0d cycles, required 1", p, bus.pix_ready, t);
            bus.pix_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.pix_valid = 1'b0;
      bus.pix_i     = 1'b0;
      bus.win_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %0b expected 0", bus.win_valid); end
      n_checks++; if (bus.window_o !== 9'h000) begin n_fail++; $display("FAIL reset_window: got %h expected 000", bus.window_o); end
      n_checks++; if (bus.win_last !== 1'b0) begin n_fail++; $display("FAIL reset_win_last: got %0b expected 0", bus.win_last); end
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done); end
      n_checks++; if (bus.pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %0b expected 1", bus.pix_ready); end
   endtask

   task automatic test_all_ones();
      int n_last;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b1;
      @(posedge clk); #1;
      clear_state();
      bus.win_ready = 1'b1;
      send_pixels(0, NPIX);
      settle();
      n_checks++; if (q_win.size() != NWIN) begin n_fail++; $display("FAIL ones_count: got %0d windows expected %0d", q_win.size(), NWIN); end
      for (int k = 0; k < q_win.size(); k++) begin
         n_checks++;
         if (q_win[k] !== 9'h1FF) begin n_fail++; $display("FAIL ones_window: idx %0d got %h expected 1ff", k, q_win[k]); break; end
      end
      n_last = 0;
      for (int k = 0; k < q_last.size(); k++) if (q_last[k] === 1'b1) n_last++;
      n_checks++; if (n_last != 1) begin n_fail++; $display("FAIL ones_last_count: got %0d win_last windows expected 1", n_last); end
      n_checks++; if (fd_cnt != 1) begin n_fail++; $display("FAIL ones_frame_done_count: got %0d pulse cycles expected 1", fd_cnt); end
      if (q_win.size() == NWIN) begin
         n_checks++; if (q_last[NWIN-1] !== 1'b1) begin n_fail++; $display("FAIL ones_last_pos: window %0d win_last=%0b expected 1", NWIN - 1, q_last[NWIN-1]); end
         n_checks++; if (fd_cyc - q_cyc[NWIN-1] != 1) begin n_fail++; $display("FAIL ones_frame_done_delay: got %0d cycles expected 1", fd_cyc - q_cyc[NWIN-1]); end
      end
   endtask

   task automatic test_checkerboard();
      logic [8:0] e;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = logic'((r + c) % 2);
      clear_state();
      send_pixels(0, NPIX);
      settle();
      n_checks++; if (q_win.size() != NWIN) begin n_fail++; $display("FAIL checker_count: got %0d windows expected %0d", q_win.size(), NWIN); end
      if (q_win.size() >= 2) begin
         n_checks++; if (q_win[0] !== 9'h0AA) begin n_fail++; $display("FAIL checker_first: got %h expected 0aa", q_win[0]); end
         n_checks++; if (q_win[1] !== 9'h155) begin n_fail++; $display("FAIL checker_second: got %h expected 155", q_win[1]); end
      end
      for (int k = 0; k < q_win.size(); k++) begin
         e = (((2 + k / (W - 2)) + (2 + k % (W - 2))) % 2 == 0) ? 9'h0AA : 9'h155;
         n_checks++;
         if (q_win[k] !== e) begin n_fail++; $display("FAIL checker_window: idx %0d got %h expected %h", k, q_win[k], e); break; end
      end
   endtask

   task automatic test_single_one();
      int nz;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b0;
      img[5][7] = 1'b1;
      clear_state();
      send_pixels(0, NPIX);
      settle();
      nz = 0;
      for (int k = 0; k < q_win.size(); k++) if (q_win[k] != 9'h000) nz++;
      n_checks++; if (nz != 9) begin n_fail++; $display("FAIL single_nonzero: got %0d nonzero windows expected 9", nz); end
      n_checks++; if (q_win.size() != NWIN) begin n_fail++; $display("FAIL single_count: got %0d windows expected %0d", q_win.size(), NWIN); end
      if (q_win.size() == NWIN) begin
         n_checks++; if (q_win[83] !== 9'h001) begin n_fail++; $display("FAIL single_topleft_3_5: got %h expected 001", q_win[83]); end
         n_checks++; if (q_win[137] !== 9'h100) begin n_fail++; $display("FAIL single_topleft_5_7: got %h expected 100", q_win[137]); end
      end
      for (int k = 0; k < q_win.size(); k++) begin
         n_checks++;
         if (q_win[k] !== exp_win(2 + k / (W - 2), 2 + k % (W - 2))) begin
            n_fail++; $display("FAIL single_window: idx %0d got %h expected %h", k, q_win[k], exp_win(2 + k / (W - 2), 2 + k % (W - 2))); break;
         end
      end
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = logic'(((r * 5 + c * 3 + r * c) % 7) < 3);
      clear_state();
      bus.win_ready = 1'b1;
      fork
         send_pixels(0, NPIX);
         begin
            int t;
            logic [8:0] held;
            t = 0;
            while (q_win.size() < 40 && t < 2000) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            bus.win_ready = 1'b0;
            @(negedge clk);
            held = bus.window_o;
            n_checks++; if (bus.win_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b expected 1", bus.win_valid); end
            n_checks++; if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pix_ready: cycle 0 got %0b expected 0", bus.pix_ready); end
            for (int i = 1; i < 10; i++) begin
               @(negedge clk);
               n_checks++; if (bus.window_o !== held) begin n_fail++; $display("FAIL stall_window_stable: cycle %0d got %h expected %h", i, bus.window_o, held); end
               n_checks++; if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pix_ready: cycle %0d got %0b expected 0", i, bus.pix_ready); end
               n_checks++; if (bus.win_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_held: cycle %0d got %0b expected 1", i, bus.win_valid); end
            end
            @(posedge clk); #1;
            bus.win_ready = 1'b1;
         end
      join
      settle();
      n_checks++; if (acc != NPIX) begin n_fail++; $display("FAIL bp_pixels: got %0d accepted expected %0d", acc, NPIX); end
      n_checks++; if (q_win.size() != NWIN) begin n_fail++; $display("FAIL bp_count: got %0d windows expected %0d", q_win.size(), NWIN); end
      for (int k = 0; k < q_win.size(); k++) begin
         n_checks++;
         if (q_win[k] !== exp_win(2 + k / (W - 2), 2 + k % (W - 2))) begin
            n_fail++; $display("FAIL bp_window: idx %0d got %h expected %h", k, q_win[k], exp_win(2 + k / (W - 2), 2 + k % (W - 2))); break;
         end
      end
   endtask

   task automatic test_reset_midframe();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b1;
      clear_state();
      bus.win_ready = 1'b1;
      send_pixels(0, 100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %0b expected 0", bus.win_valid); end
      n_checks++; if (bus.window_o !== 9'h000) begin n_fail++; $display("FAIL mid_reset_window: got %h expected 000", bus.window_o); end
      @(posedge clk); #1;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b0;
      clear_state();
      send_pixels(0, NPIX);
      settle();
      n_checks++; if (q_win.size() != NWIN) begin n_fail++; $display("FAIL mid_count: got %0d windows expected %0d", q_win.size(), NWIN); end
      if (q_win.size() > 0) begin
         n_checks++; if (q_acc[0] != 59) begin n_fail++; $display("FAIL mid_first_latency: first window after %0d pixels expected 59", q_acc[0]); end
      end
      for (int k = 0; k < q_win.size(); k++) begin
         n_checks++;
         if (q_win[k] !== 9'h000) begin n_fail++; $display("FAIL mid_window: idx %0d got %h expected 000", k, q_win[k]); break; end
      end
   endtask

   task automatic test_back_to_back();
      int n_last;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = logic'(((r * 3 + c) % 4) == 1);
      clear_state();
      bus.win_ready = 1'b1;
      send_pixels(0, 2 * NPIX);
      settle();
      n_checks++; if (q_win.size() != 2 * NWIN) begin n_fail++; $display("FAIL b2b_count: got %0d windows expected %0d", q_win.size(), 2 * NWIN); end
      n_checks++; if (stall_cnt != 1) begin n_fail++; $display("FAIL b2b_stall: got %0d stall cycles expected 1", stall_cnt); end
      n_checks++; if (fd_cnt != 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses expected 2", fd_cnt); end
      n_last = 0;
      for (int k = 0; k < q_last.size(); k++) if (q_last[k] === 1'b1) n_last++;
      n_checks++; if (n_last != 2) begin n_fail++; $display("FAIL b2b_last_count: got %0d expected 2", n_last); end
      if (q_win.size() == 2 * NWIN) begin
         n_checks++; if (q_last[NWIN-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_last_frame1: got %0b expected 1", q_last[NWIN-1]); end
      end
      for (int k = 0; k < q_win.size(); k++) begin
         n_checks++;
         if (q_win[k] !== exp_win(2 + (k % NWIN) / (W - 2), 2 + (k % NWIN) % (W - 2))) begin
            n_fail++; $display("FAIL b2b_window: idx %0d got %h expected %h", k, q_win[k], exp_win(2 + (k % NWIN) / (W - 2), 2 + (k % NWIN) % (W - 2))); break;
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.pix_valid = 1'b0;
      bus.pix_i     = 1'b0;
      bus.win_ready = 1'b1;
      test_reset();
      test_all_ones();
      test_checkerboard();
      test_single_one();
      test_backpressure();
      test_reset_midframe();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
